// File: rtl/prog_mod_counter_pkg.sv
// Shared clock-digit package: terminal-behaviour modes and the standard digit moduli.
package prog_mod_counter_pkg;

  // What a counter does when it is enabled at its terminal value
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Moduli of the existing clock digits
  localparam int unsigned DIGIT_MOD_DEC      = 10;
  localparam int unsigned DIGIT_MOD_SEXT     = 6;
  localparam int unsigned DIGIT_MOD_HRS_TENS = 3;
  localparam int unsigned MOD_HOURS          = 24;
  localparam int unsigned MOD_MIN_SEC        = 60;

  // Default digit width, wide enough for any single decimal digit
  localparam int unsigned DIGIT_WIDTH = 4;

endpackage

// File: rtl/prog_mod_counter_if.sv
// Control/status bundle of one programmable-modulus counter digit.
interface prog_mod_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic             Up_Down_en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             at_limit;

  // Driver side: whoever controls the digit
  modport master (
    output en,
    output Up_Down_en,
    output load,
    output load_val,
    output modulus,
    input  count,
    input  carry,
    input  at_limit
  );

  // Counter side
  modport slave (
    input  en,
    input  Up_Down_en,
    input  load,
    input  load_val,
    input  modulus,
    output count,
    output carry,
    output at_limit
  );

endinterface

// File: rtl/prog_mod_counter.sv
// Up/down counter with a runtime modulus, synchronous clamped load and
// wrap or saturate terminal behaviour. carry is combinational so a chain of
// digits advances in the same cycle.
module prog_mod_counter
  import prog_mod_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter mode_e       MODE  = MODE_WRAP
) (
  input  logic                clk,
  input  logic                rst,
  prog_mod_counter_if.slave   bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] neff_m1;
  logic [WIDTH-1:0] load_clamped;
  logic             up;
  logic             out_of_range;
  logic             limit;

  // Largest legal count; modulus 0 behaves as modulus 1 so this never underflows
  always_comb begin
    neff_m1 = '0;
    if (bus.modulus != '0) begin
      neff_m1 = bus.modulus - WIDTH'(1);
    end
  end

  // Terminal detection for the current direction and range check after a modulus change
  always_comb begin
    up           = bus.Up_Down_en;
    out_of_range = (count_q > neff_m1);
    limit        = up ? (count_q == neff_m1) : (count_q == '0);
    load_clamped = (bus.load_val > neff_m1) ? neff_m1 : bus.load_val;
  end

  // Next count: load beats range correction beats counting beats hold
  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = load_clamped;
    end else if (out_of_range) begin
      count_d = '0;
    end else if (bus.en) begin
      if (limit) begin
        if (MODE == MODE_WRAP) begin
          count_d = up ? '0 : neff_m1;
        end
      end else begin
        count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
      end
    end
  end

  // Count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Outputs; an out-of-range count is never a terminal value, so carry stays low then
  assign bus.count    = count_q;
  assign bus.at_limit = limit;
  assign bus.carry    = bus.en & limit & ~bus.load;

endmodule

// File: tb/tb_prog_mod_counter.sv
// Bench for prog_mod_counter: a wrap and a saturate instance driven in
// parallel, checked against an integer reference model.
module tb_prog_mod_counter;
  import prog_mod_counter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_s = 1'b0;
  logic       ud_s = 1'b1;
  logic       load_s = 1'b0;
  logic [3:0] load_val_s = 4'd0;
  logic [3:0] modulus_s = 4'd10;

  int total = 0;
  int passed = 0;
  int mw = 0;   // reference count, wrap instance
  int ms = 0;   // reference count, saturate instance

  prog_mod_counter_if #(.WIDTH(4)) bw ();
  prog_mod_counter_if #(.WIDTH(4)) bs ();

  assign bw.en = en_s;       assign bs.en = en_s;
  assign bw.Up_Down_en = ud_s; assign bs.Up_Down_en = ud_s;
  assign bw.load = load_s;   assign bs.load = load_s;
  assign bw.load_val = load_val_s; assign bs.load_val = load_val_s;
  assign bw.modulus = modulus_s;   assign bs.modulus = modulus_s;

  prog_mod_counter #(.WIDTH(4), .MODE(MODE_WRAP)) dut_wrap (.clk(clk), .rst(rst), .bus(bw));
  prog_mod_counter #(.WIDTH(4), .MODE(MODE_SAT))  dut_sat  (.clk(clk), .rst(rst), .bus(bs));

  always #5 clk = ~clk;

  function automatic int neff(input int md);
    return (md == 0) ? 1 : md;
  endfunction

  function automatic bit ref_limit(input int c, input bit ud, input int md);
    return ud ? (c == neff(md) - 1) : (c == 0);
  endfunction

  function automatic int ref_next(input int c, input bit sat, input bit e, input bit ud,
                                  input bit ld, input int lv, input int md);
    int n;
    n = neff(md);
    if (ld) return (lv < n) ? lv : n - 1;
    if (c >= n) return 0;
    if (!e) return c;
    if (ud) begin
      if (c == n - 1) return sat ? c : 0;
      return c + 1;
    end
    if (c == 0) return sat ? c : n - 1;
    return c - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === 32'(exp)) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check count
  task automatic step(input bit e, input bit ud, input bit ld, input int lv, input int md);
    bit lw, ls;
    en_s = e; ud_s = ud; load_s = ld; load_val_s = 4'(lv); modulus_s = 4'(md);
    #1;
    lw = ref_limit(mw, ud, md);
    ls = ref_limit(ms, ud, md);
    chk("wrap_at_limit", 32'(bw.at_limit), int'(lw));
    chk("sat_at_limit",  32'(bs.at_limit), int'(ls));
    chk("wrap_carry", 32'(bw.carry), int'(e && lw && !ld));
    chk("sat_carry",  32'(bs.carry), int'(e && ls && !ld));
    @(posedge clk);
    mw = ref_next(mw, 1'b0, e, ud, ld, lv, md);
    ms = ref_next(ms, 1'b1, e, ud, ld, lv, md);
    #1;
    chk("wrap_count", 32'(bw.count), mw);
    chk("sat_count",  32'(bs.count), ms);
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 rst = 1'b0;
    #2;
    chk("reset_wrap_count", 32'(bw.count), 0);
    chk("reset_sat_count",  32'(bs.count), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_hold", 32'(bw.count), 0);

    // Up count through N=10: 0..9,0,1 over twelve observed cycles
    for (int i = 0; i < 11; i++) step(1'b1, 1'b1, 1'b0, 0, 10);
    chk("up10_final", 32'(bw.count), 1);

    // Down from 0 wraps to 9
    step(1'b0, 1'b1, 1'b1, 0, 10);
    step(1'b1, 1'b0, 1'b0, 0, 10);
    chk("down10_wrap", 32'(bw.count), 9);

    // Load above range clamps; load suppresses carry even at the limit
    en_s = 1'b1; ud_s = 1'b1; load_s = 1'b1; load_val_s = 4'd12; modulus_s = 4'd10;
    #1;
    chk("load_limit_seen", 32'(bw.at_limit), 1);
    chk("load_carry_low",  32'(bw.carry), 0);
    step(1'b1, 1'b1, 1'b1, 12, 10);
    chk("load_clamp", 32'(bw.count), 9);

    // Lowering the modulus below the count resets it without enable
    step(1'b0, 1'b1, 1'b1, 7, 10);
    step(1'b0, 1'b1, 1'b0, 0, 5);
    chk("modulus_drop", 32'(bw.count), 0);

    // Saturate at N=6
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 0, 6);
    chk("sat_stop", 32'(bs.count), 5);
    chk("sat_limit_held", 32'(bs.at_limit), 1);
    chk("sat_carry_held", 32'(bs.carry), 1);

    // Mid-count asynchronous reset at count 4
    step(1'b0, 1'b1, 1'b1, 0, 10);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 10);
    chk("pre_reset_count", 32'(bw.count), 4);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_wrap", 32'(bw.count), 0);
    chk("async_reset_sat",  32'(bs.count), 0);
    chk("reset_carry", 32'(bw.carry), 0);
    en_s = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mw = 0; ms = 0;
    @(posedge clk); #1;

    // Modulus 0: stuck at 0 with carry every enabled cycle
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 0, 0);
    chk("mod0_count", 32'(bw.count), 0);

    // Randomised traffic against the reference model
    begin
      int md;
      md = 10;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 5) == 0) md = int'($urandom_range(0, 15));
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)), md);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, bit width of count, modulus and load value.
REQ-002 SHALL have parameter: MODE, MODE_WRAP, terminal behaviour (MODE_WRAP or MODE_SAT, from the shared package).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: en  input  1  count enable.
REQ-006 SHALL have port: Up_Down_en  input  1  direction; 1 = up, 0 = down.
REQ-007 SHALL have port: load  input  1  synchronous load strobe.
REQ-008 SHALL have port: load_val  input  WIDTH  value for load.
REQ-009 SHALL have port: modulus  input  WIDTH  runtime modulus N; count range is 0..N-1.
REQ-010 SHALL have port: count  output  WIDTH  registered counter value.
REQ-011 SHALL have port: carry  output  1  combinational cascade/terminal strobe for the next digit's en.
REQ-012 SHALL have port: at_limit  output  1  combinational; count equals the terminal value for the current direction.

Function
REQ-013 SHALL define effective modulus Neff = 1 when modulus is 0, else modulus.
REQ-014 SHALL define the terminal value as Neff-1 when Up_Down_en=1, and 0 when Up_Down_en=0.
REQ-015 SHALL drive at_limit = (count == terminal value), independent of en.
REQ-016 SHALL drive carry = en & at_limit & ~load, so a chain of counters ticks in the same cycle.
REQ-017 SHALL apply per-edge priority: load, then out-of-range correction, then en counting, then hold.
REQ-018 SHALL, on load, set count = load_val if load_val < Neff, else Neff-1 (clamp); en is ignored in that cycle.
REQ-019 SHALL, when count >= Neff and load=0 (modulus lowered at runtime), set count = 0 on the next edge regardless of en, without asserting carry.
REQ-020 SHALL, with en=1 and not at_limit, increment by 1 when up and decrement by 1 when down.
REQ-021 SHALL, with MODE_WRAP, en=1 and at_limit, go Neff-1 -> 0 when up and 0 -> Neff-1 when down.
REQ-022 SHALL, with MODE_SAT, en=1 and at_limit, hold count (carry still asserts per REQ-016).
REQ-023 SHALL, with Neff=1, hold count at 0 and assert carry on every enabled cycle.
REQ-024 SHALL, with en=0 and no load/correction, hold count.
REQ-025 SHALL reflect a direction change on the next enabled edge (no latency beyond one clock).
REQ-026 SHALL perform all arithmetic in WIDTH bits with no overflow; Neff-1 SHALL be computed without underflow.

Reset
REQ-027 SHALL force count = 0 immediately when rst=0, independent of clk.
REQ-028 SHALL hold count = 0 while rst=0; at_limit and carry follow REQ-015/016 from count = 0.
REQ-029 SHALL count from 0 on the first rising edge after rst deasserts; reset mid-count discards state.

Structure
REQ-030 SHALL take MODE_WRAP/MODE_SAT constants from the shared clock package, alongside the existing digit moduli (10, 6, 3, 24, 60).
REQ-031 SHALL be a single module with no sub-module; existing fixed-modulus wrappers (e.g. hours-tens) SHALL be re-expressed as instances with modulus tied to a constant.

Verification
REQ-032 SHALL check: WIDTH=4, WRAP, N=10, up, en=1 for 12 cycles from reset -> count 0..9,0,1; carry high only while count=9.
REQ-033 SHALL check: N=10, down from 0 with en=1 -> count 9 after one edge; carry high while count=0.
REQ-034 SHALL check: SAT, N=6, up, en=1 for 8 cycles -> count stops at 5; carry high from count=5 onward; at_limit=1.
REQ-035 SHALL check: load=1, load_val=12, N=10 -> count=9; the same cycle with en=1 gives carry=0.
REQ-036 SHALL check: count=7, modulus changed 10->5, en=0 -> count=0 after one edge, carry=0.
REQ-037 SHALL check: rst pulled low between edges at count=4 -> count=0 before the next edge; modulus=0 with en=1 -> count stays 0 and carry=1 every cycle.
